nms_keypoint_collector: RTL and testbench

// - Sink for the NMS keypoint stream; downstream consumer of nms_valid/score/x/y.
// - NMS keypoints arrive as single-cycle pulses with no backpressure. This block buffers them in a FIFO.
// - Caps keypoints per frame and inserts an end-of-frame marker carrying the accepted count.
// - Presents records on a valid/ready interface to descriptor/DMA stages.

---
 rtl/nms_keypoint_collector_if.sv | 35 +++
 rtl/nms_keypoint_collector.sv | 164 ++++++++++++++++
 tb/tb_nms_keypoint_collector.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nms_keypoint_collector_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nms_keypoint_collector_if                                  |
// | Description : Keypoint record stream (valid/ready) from the keypoint     |
// |               collector to the descriptor/DMA stages.                    |
// |   master : drives kp_valid, kp_last, kp_score, kp_x, kp_y, kp_count;     |
// |            samples kp_ready                                              |
// |   slave  : the consumer side of the same signals                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface nms_keypoint_collector_if #(
  parameter int SCORE_WIDTH = 8,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int CNT_W       = 11
);
  logic                   kp_valid;
  logic                   kp_ready;
  logic                   kp_last;
  logic [SCORE_WIDTH-1:0] kp_score;
  logic [X_W-1:0]         kp_x;
  logic [Y_W-1:0]         kp_y;
  logic [CNT_W-1:0]       kp_count;

  modport master (
    output kp_valid, kp_last, kp_score, kp_x, kp_y, kp_count,
    input  kp_ready
  );

  modport slave (
    input  kp_valid, kp_last, kp_score, kp_x, kp_y, kp_count,
    output kp_ready
  );
endinterface
`default_nettype wire

// File: rtl/nms_keypoint_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nms_keypoint_collector                                     |
// | Description : Buffers single-cycle NMS keypoint pulses in a FIFO, caps   |
// |               keypoints per frame, appends an end-of-frame marker that   |
// |               carries the accepted count, and streams records out on a   |
// |               valid/ready interface.                                     |
// | Ports       : clk, rst_n (async, active low)                             |
// |               nms_valid/score/x/y  keypoint pulses (no backpressure)     |
// |               frame_start          clears the per-frame count            |
// |               frame_end            requests an end-of-frame marker       |
// |               min_score            only with NMS_KP_SCORE_THRESH_EN      |
// |               kp (master)          record stream                         |
// |               drop_count           saturating dropped-keypoint count     |
// |               fifo_level           current FIFO occupancy                |
// | Options     : `define NMS_KP_SCORE_THRESH_EN adds min_score; keypoints   |
// |               scoring below it are discarded without being counted.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module nms_keypoint_collector #(
  parameter int SCORE_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 64,
  parameter int MAX_KP       = 1024,
  localparam int c_x_w   = $clog2(IMAGE_WIDTH),
  localparam int c_y_w   = $clog2(IMAGE_HEIGHT),
  localparam int c_cnt_w = $clog2(MAX_KP + 1),
  localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1
) (
  input  wire                    clk,
  input  wire                    rst_n,
  input  wire                    nms_valid,
  input  wire  [SCORE_WIDTH-1:0] nms_score,
  input  wire  [c_x_w-1:0]       nms_x,
  input  wire  [c_y_w-1:0]       nms_y,
  input  wire                    frame_start,
  input  wire                    frame_end,
`ifdef NMS_KP_SCORE_THRESH_EN
  input  wire  [SCORE_WIDTH-1:0] min_score,
`endif
  nms_keypoint_collector_if.master kp,
  output logic [15:0]            drop_count,
  output logic [c_lvl_w-1:0]     fifo_level
);

  localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int c_xy_w    = c_x_w + c_y_w;
  localparam int c_entry_w = 1 + SCORE_WIDTH + c_xy_w;

  localparam logic [c_lvl_w-1:0] c_depth    = c_lvl_w'(FIFO_DEPTH);
  localparam logic [c_lvl_w-1:0] c_depth_m1 = c_lvl_w'(FIFO_DEPTH - 1);
  localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_max_kp   = c_cnt_w'(MAX_KP);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  // Entry layout: {last, score, x, y}; a marker is {1, 0, count zero-extended}
  logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level;
  logic [c_cnt_w-1:0]   r_frame_cnt;
  logic                 r_marker_pending;
  logic [15:0]          r_drop_count;

  logic                 w_kp_cand;
  logic                 w_kp_accept;
  logic                 w_kp_drop;
  logic                 w_marker_write;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_kp_valid;
  logic                 w_rd_last;
  logic [c_entry_w-1:0] w_wr_entry;
  logic [c_entry_w-1:0] w_rd_entry;

`ifdef NMS_KP_SCORE_THRESH_EN
  assign w_kp_cand = nms_valid & (nms_score >= min_score);
`else
  assign w_kp_cand = nms_valid;
`endif

  assign w_kp_valid = (r_level != '0);
  assign w_pop      = w_kp_valid & kp.kp_ready;

  // The top slot is kept free so the marker can always be written.
  assign w_kp_accept = w_kp_cand & ~r_marker_pending &
                       (r_level < c_depth_m1) & (r_frame_cnt < c_max_kp);
  assign w_kp_drop   = w_kp_cand & ~w_kp_accept;

  // A keypoint is never accepted while a marker is pending, so the two
  // write sources are mutually exclusive.
  assign w_marker_write = r_marker_pending & (r_level < c_depth);
  assign w_push         = w_kp_accept | w_marker_write;

  assign w_wr_entry = w_marker_write ?
                      {1'b1, {SCORE_WIDTH{1'b0}}, c_xy_w'(r_frame_cnt)} :
                      {1'b0, nms_score, nms_x, nms_y};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_level          <= '0;
      r_frame_cnt      <= '0;
      r_marker_pending <= 1'b0;
      r_drop_count     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase

      // A keypoint accepted alongside frame_start belongs to the new frame.
      if (frame_start) begin
        r_frame_cnt <= w_kp_accept ? c_cnt_one : '0;
      end else if (w_kp_accept) begin
        r_frame_cnt <= r_frame_cnt + c_cnt_one;
      end

      // A fresh frame_end wins over the marker write that retires the old one.
      if (frame_end) begin
        r_marker_pending <= 1'b1;
      end else if (w_marker_write) begin
        r_marker_pending <= 1'b0;
      end

      if (w_kp_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // Outputs come straight from the head entry, so they hold while stalled;
  // fields that do not apply to the record type read as zero.
  assign w_rd_entry = r_mem[r_rd_ptr];
  assign w_rd_last  = w_rd_entry[c_entry_w-1];

  assign kp.kp_valid = w_kp_valid;
  assign kp.kp_last  = w_kp_valid & w_rd_last;
  assign kp.kp_score = (w_kp_valid & ~w_rd_last) ? w_rd_entry[c_xy_w +: SCORE_WIDTH] : '0;
  assign kp.kp_x     = (w_kp_valid & ~w_rd_last) ? w_rd_entry[c_y_w +: c_x_w] : '0;
  assign kp.kp_y     = (w_kp_valid & ~w_rd_last) ? w_rd_entry[0 +: c_y_w] : '0;
  assign kp.kp_count = (w_kp_valid & w_rd_last) ? w_rd_entry[0 +: c_cnt_w] : '0;

  assign drop_count = r_drop_count;
  assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_nms_keypoint_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_nms_keypoint_collector                                  |
// | Description : Scoreboard bench for nms_keypoint_collector. Two instances |
// |               (MAX_KP=1024 and MAX_KP=4) share stimulus; a queue-based   |
// |               reference model predicts each one's record stream.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_nms_keypoint_collector;

  localparam int DEPTH = 64;

  typedef struct {
    bit last;
    int score;
    int x;
    int y;
    int cnt;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nms_valid = 1'b0;
  logic [7:0] nms_score = '0;
  logic [9:0] nms_x = '0;
  logic [8:0] nms_y = '0;
  logic       frame_start = 1'b0;
  logic       frame_end = 1'b0;
  logic       ready = 1'b1;
  logic [15:0] drop0, drop1;
  logic [6:0]  lvl0, lvl1;
`ifdef NMS_KP_SCORE_THRESH_EN
  logic [7:0] min_score = '0;
`endif

  nms_keypoint_collector_if #(.SCORE_WIDTH(8), .X_W(10), .Y_W(9), .CNT_W(11)) kp0 ();
  nms_keypoint_collector_if #(.SCORE_WIDTH(8), .X_W(10), .Y_W(9), .CNT_W(3))  kp1 ();
  assign kp0.kp_ready = ready;
  assign kp1.kp_ready = ready;

  nms_keypoint_collector #(.FIFO_DEPTH(DEPTH), .MAX_KP(1024)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .nms_valid(nms_valid), .nms_score(nms_score),
    .nms_x(nms_x), .nms_y(nms_y), .frame_start(frame_start), .frame_end(frame_end),
`ifdef NMS_KP_SCORE_THRESH_EN
    .min_score(min_score),
`endif
    .kp(kp0.master), .drop_count(drop0), .fifo_level(lvl0)
  );

  nms_keypoint_collector #(.FIFO_DEPTH(DEPTH), .MAX_KP(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .nms_valid(nms_valid), .nms_score(nms_score),
    .nms_x(nms_x), .nms_y(nms_y), .frame_start(frame_start), .frame_end(frame_end),
`ifdef NMS_KP_SCORE_THRESH_EN
    .min_score(min_score),
`endif
    .kp(kp1.master), .drop_count(drop1), .fifo_level(lvl1)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int   m_level [2];
  int   m_cnt   [2];
  int   m_drop  [2];
  bit   m_pend  [2];
  int   m_maxkp [2] = '{1024, 4};
  rec_t exp_q0 [$];
  rec_t exp_q1 [$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input int d, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, exp);
  endtask

  function automatic int thr();
`ifdef NMS_KP_SCORE_THRESH_EN
    return int'(min_score);
`else
    return 0;
`endif
  endfunction

  task automatic push_exp(input int d, input rec_t r);
    if (d == 0) exp_q0.push_back(r);
    else        exp_q1.push_back(r);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_level[d] = 0; m_cnt[d] = 0; m_drop[d] = 0; m_pend[d] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // One clock of the collector's rules, evaluated on this cycle's inputs.
  task automatic model_step(input int d);
    bit   pop, cand, acc, mk;
    rec_t r;
    pop  = (m_level[d] > 0) && ready;
    cand = nms_valid && (int'(nms_score) >= thr());
    acc  = cand && !m_pend[d] && (m_level[d] < DEPTH - 1) && (m_cnt[d] < m_maxkp[d]);
    mk   = m_pend[d] && (m_level[d] < DEPTH);
    if (cand && !acc && m_drop[d] < 65535) m_drop[d]++;
    if (acc) begin
      r.last = 1'b0; r.score = int'(nms_score); r.x = int'(nms_x); r.y = int'(nms_y); r.cnt = 0;
      push_exp(d, r);
    end
    if (mk) begin
      r.last = 1'b1; r.score = 0; r.x = 0; r.y = 0; r.cnt = m_cnt[d];
      push_exp(d, r);
    end
    if (frame_start) m_cnt[d] = acc ? 1 : 0;
    else if (acc)    m_cnt[d]++;
    if (frame_end)   m_pend[d] = 1'b1;
    else if (mk)     m_pend[d] = 1'b0;
    m_level[d] += int'(acc) + int'(mk) - int'(pop);
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- monitor ----------------
  task automatic mon(input int d, input logic v, input logic last, input int sc,
                     input int x, input int y, input int cnt, input int lvl, input int drop);
    rec_t e;
    bit   empty;
    chk("kp_valid", d, longint'(v), longint'(m_level[d] > 0));
    chk("fifo_level", d, lvl, m_level[d]);
    chk("drop_count", d, drop, m_drop[d]);
    if (v === 1'b1) begin
      empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      if (empty) begin
        chk("sb_underflow", d, 1, 0);
      end else begin
        e = (d == 0) ? exp_q0[0] : exp_q1[0];
        chk("kp_last", d, longint'(last), longint'(e.last));
        if (e.last) begin
          chk("kp_count", d, cnt, e.cnt);
          chk("marker_score", d, sc, 0);
        end else begin
          chk("kp_score", d, sc, e.score);
          chk("kp_x", d, x, e.x);
          chk("kp_y", d, y, e.y);
        end
        if (ready) begin
          if (d == 0) void'(exp_q0.pop_front());
          else        void'(exp_q1.pop_front());
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      mon(0, kp0.kp_valid, kp0.kp_last, int'(kp0.kp_score), int'(kp0.kp_x), int'(kp0.kp_y),
          int'(kp0.kp_count), int'(lvl0), int'(drop0));
      mon(1, kp1.kp_valid, kp1.kp_last, int'(kp1.kp_score), int'(kp1.kp_x), int'(kp1.kp_y),
          int'(kp1.kp_count), int'(lvl1), int'(drop1));
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] sc, input logic [9:0] x, input logic [8:0] y, input bit fe);
    nms_valid = 1'b1; nms_score = sc; nms_x = x; nms_y = y; frame_end = fe;
    tick();
    nms_valid = 1'b0; frame_end = 1'b0;
  endtask

  task automatic ctrl(input bit fs, input bit fe);
    frame_start = fs; frame_end = fe;
    tick();
    frame_start = 1'b0; frame_end = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done  = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (m_level[0] == 0 && m_level[1] == 0 && !m_pend[0] && !m_pend[1]) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    tick();
    chk("drain_done", 0, longint'(done), 1);
    chk("sb_leftover0", 0, exp_q0.size(), 0);
    chk("sb_leftover1", 1, exp_q1.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int d1;
    int pulses;
    bit nv;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_kp_valid", 0, kp0.kp_valid, 0);
    chk("rst_kp_last", 0, kp0.kp_last, 0);
    chk("rst_kp_score", 0, kp0.kp_score, 0);
    chk("rst_kp_x", 0, kp0.kp_x, 0);
    chk("rst_kp_y", 0, kp0.kp_y, 0);
    chk("rst_kp_count", 0, kp0.kp_count, 0);
    chk("rst_drop", 0, drop0, 0);
    chk("rst_level", 0, lvl0, 0);
    chk("rst_kp_valid", 1, kp1.kp_valid, 0);
    rst_n = 1'b1;
    tick();

    // Three keypoints then an end-of-frame marker with count 3
    pulse(8'd10, 10'd5, 9'd9, 1'b0);
    pulse(8'd20, 10'd6, 9'd9, 1'b0);
    pulse(8'd30, 10'd7, 9'd9, 1'b0);
    ctrl(1'b0, 1'b1);
    drain();

    // Per-frame cap: dut1 takes 4 of 6
    ctrl(1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      pulse(8'($urandom_range(255)), 10'($urandom_range(639)), 9'($urandom_range(479)), 1'b0);
    ctrl(1'b0, 1'b1);
    drain();
    chk("maxkp_drop", 1, drop1, 2);
    chk("maxkp_drop_uncapped", 0, drop0, 0);

    // Stalled output: 70 pulses fill 63 slots, then the marker takes the last one
    ctrl(1'b1, 1'b0);
    ready = 1'b0;
    for (int i = 0; i < 70; i++)
      pulse(8'(i), 10'(i), 9'(i + 1), 1'b0);
    tick();
    chk("full_level", 0, lvl0, 63);
    chk("full_drop", 0, drop0, 7);
    ctrl(1'b0, 1'b1);
    tick();
    chk("marker_level", 0, lvl0, 64);
    drain();

    // Keypoint coinciding with frame_end, then one while the marker is pending
    ctrl(1'b1, 1'b0);
    d0 = int'(drop0);
    pulse(8'd77, 10'd1, 9'd2, 1'b1);
    pulse(8'd78, 10'd3, 9'd4, 1'b0);
    tick();
    chk("samecycle_drop", 0, drop0, d0 + 1);
    drain();

    // Random traffic with random backpressure
    ctrl(1'b1, 1'b0);
    pulses = 0;
    while (pulses < 1000) begin
      nv          = ($urandom_range(1) == 1);
      nms_valid   = nv;
      nms_score   = 8'($urandom_range(255));
      nms_x       = 10'($urandom_range(639));
      nms_y       = 9'($urandom_range(479));
      frame_start = !nv && ($urandom_range(59) == 0);
      frame_end   = ($urandom_range(39) == 0);
      ready       = ($urandom_range(9) < 6);
      if (nv) pulses++;
      tick();
    end
    nms_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    ctrl(1'b0, 1'b1);
    drain();

`ifdef NMS_KP_SCORE_THRESH_EN
    ctrl(1'b1, 1'b0);
    min_score = 8'd50;
    d0 = int'(drop0);
    d1 = int'(drop1);
    pulse(8'd49, 10'd1, 9'd1, 1'b0);
    pulse(8'd50, 10'd2, 9'd1, 1'b0);
    pulse(8'd51, 10'd3, 9'd1, 1'b0);
    ctrl(1'b0, 1'b1);
    drain();
    chk("thresh_drop", 0, drop0, d0);
    chk("thresh_drop", 1, drop1, d1);
    min_score = 8'd0;
`endif

    // Reset in the middle of a frame with records waiting
    ctrl(1'b1, 1'b0);
    ready = 1'b0;
    pulse(8'd1, 10'd1, 9'd1, 1'b0);
    pulse(8'd2, 10'd2, 9'd2, 1'b0);
    pulse(8'd3, 10'd3, 9'd3, 1'b0);
    @(posedge clk);
    #3;
    chk("prerst_valid", 0, kp0.kp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 0, kp0.kp_valid, 0);
    chk("async_rst_valid", 1, kp1.kp_valid, 0);
    chk("async_rst_level", 0, lvl0, 0);
    chk("async_rst_drop", 0, drop0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 0, kp0.kp_valid, 0);
    ready = 1'b1;
    pulse(8'd99, 10'd9, 9'd9, 1'b0);
    ctrl(1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
